// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-source encodings (common with the ID decoder),
// fetch FSM states and the bubble instruction word.
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DRAIN,
    FETCH_FULL
  } fetch_state_e;

  // j/jal target: region bits of the delay-slot PC joined with the word index
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc4} holding register that catches a fetched word
// arriving while the decode stage is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Clear wins over load so a redirect always empties the buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
    end else if (load && !clear) begin
      instr <= load_instr;
      pc4   <= load_pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// writes IF/ID and applies EX-branch / ID-jump redirects with stale-fetch squashing.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_if,
  input  logic [1:0]  id_pcsrc,
  input  logic [25:0] id_target,
  input  logic [31:0] id_rs_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        id_flush
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  stale_addr;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         jump_ok;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc4;
  logic         skid_valid;

  assign pc_plus4  = pc + 32'd4;
  assign id_flush  = ex_branch_taken;
  assign imem_req  = (state == FETCH_REQ) || (state == FETCH_DRAIN);
  assign imem_addr = (state == FETCH_DRAIN) ? stale_addr : pc;

  // Redirect select: EX branch overrides everything; an ID jump only counts
  // for a real instruction that is not being held by the hazard unit.
  always_comb begin
    jump_ok     = if_id_valid && !stall_if;
    redirect    = 1'b0;
    redirect_pc = pc;
    if (ex_branch_taken) begin
      redirect    = 1'b1;
      redirect_pc = ex_branch_target;
    end else if (jump_ok && (id_pcsrc == PCSRC_JUMP)) begin
      redirect    = 1'b1;
      redirect_pc = jump_target(if_id_pc4, id_target);
    end else if (jump_ok && (id_pcsrc == PCSRC_JR)) begin
      redirect    = 1'b1;
      redirect_pc = id_rs_data;
    end
  end

  assign skid_load  = (state == FETCH_REQ) && imem_ack && !redirect && stall_if;
  assign skid_clear = redirect || ((state == FETCH_FULL) && !stall_if);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc4   (pc_plus4),
    .instr      (skid_instr),
    .pc4        (skid_pc4),
    .valid      (skid_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_PC;
      stale_addr  <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      case (state)
        FETCH_REQ: begin
          // An un-acked request is still in flight at the old PC; remember it
          if (!imem_ack) begin
            state      <= FETCH_DRAIN;
            stale_addr <= pc;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ack) state <= FETCH_REQ;
        end
        default: state <= FETCH_REQ;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: state <= FETCH_REQ;
        FETCH_REQ: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            if (stall_if) begin
              state <= FETCH_FULL;
            end else begin
              if_id_instr <= imem_rdata;
              if_id_pc4   <= pc_plus4;
              if_id_valid <= 1'b1;
            end
          end
        end
        FETCH_DRAIN: begin
          if (imem_ack) state <= FETCH_REQ;
        end
        FETCH_FULL: begin
          if (!stall_if) begin
            if_id_instr <= skid_instr;
            if_id_pc4   <= skid_pc4;
            if_id_valid <= skid_valid;
            state       <= FETCH_REQ;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle stimulus and expected IF/ID + request state
// are queued together, then replayed and compared one clock at a time.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_if = 1'b0;
  logic [1:0]  id_pcsrc = 2'b00;
  logic [25:0] id_target = '0;
  logic [31:0] id_rs_data = '0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        id_flush;

  int n_vec = 0;
  int n_err = 0;

  // Memory model: acks after wait_n cycles of req, data = addr >> 2
  int   wait_n = 0;
  int   wcnt = 0;
  logic ack_force = 1'b0;

  assign imem_ack   = (imem_req && (wcnt == wait_n)) || ack_force;
  assign imem_rdata = imem_addr >> 2;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .stall_if         (stall_if),
    .id_pcsrc         (id_pcsrc),
    .id_target        (id_target),
    .id_rs_data       (id_rs_data),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid),
    .id_flush         (id_flush)
  );

  typedef struct {
    logic        stall;
    logic [1:0]  pcsrc;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic        br;
    logic [31:0] brt;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];

  function automatic stim_t mk_s(logic st, logic [1:0] ps, logic [25:0] tg,
                                 logic [31:0] rs, logic br, logic [31:0] brt);
    stim_t s;
    s.stall = st; s.pcsrc = ps; s.tgt = tg; s.rs = rs; s.br = br; s.brt = brt;
    return s;
  endfunction

  function automatic exp_t mk_e(logic v, logic [31:0] i, logic [31:0] p,
                                logic r, logic [31:0] a);
    exp_t e;
    e.valid = v; e.instr = i; e.pc4 = p; e.req = r; e.addr = a;
    return e;
  endfunction

  function automatic stim_t s0();
    return mk_s(1'b0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    stall_if         = s.stall;
    id_pcsrc         = s.pcsrc;
    id_target        = s.tgt;
    id_rs_data       = s.rs;
    ex_branch_taken  = s.br;
    ex_branch_target = s.brt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ack_force = 1'b0;
    apply(s0());
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, id_flush} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got req=%0d v=%0d instr=%h pc4=%h flush=%0d, want 0 0 00000000 00000000 0",
               imem_req, if_id_valid, if_id_instr, if_id_pc4, id_flush);
    end
  endtask

  task automatic test_seq();
    stim_t s; exp_t e; int cyc;
    wait_n = 0;
    do_reset();
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(1, 32'h0, 32'h4, 1, 32'h4));
    push(s0(), mk_e(1, 32'h1, 32'h8, 1, 32'h8));
    push(s0(), mk_e(1, 32'h2, 32'hC, 1, 32'hC));
    push(s0(), mk_e(1, 32'h3, 32'h10, 1, 32'h10));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL seq c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_jump();
    stim_t s; exp_t e; int cyc;
    push(mk_s(0, 2'b01, 26'h40, 32'h0, 0, 32'h0), mk_e(0, 32'h0, 32'h0, 1, 32'h100));
    push(s0(), mk_e(1, 32'h40, 32'h104, 1, 32'h104));
    push(s0(), mk_e(1, 32'h41, 32'h108, 1, 32'h108));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL jump c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_branch_wait();
    stim_t s; exp_t e; int cyc;
    wait_n = 3;
    do_reset();
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(mk_s(0, 2'b00, 26'h0, 32'h0, 1, 32'h80), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h80));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h80));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h80));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h80));
    push(s0(), mk_e(1, 32'h20, 32'h84, 1, 32'h84));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      #1;
      n_vec++;
      if (id_flush !== s.br) begin
        n_err++;
        $display("FAIL branch_flush c%0d: got %0d, want %0d", cyc, id_flush, s.br);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL branch c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s; exp_t e; int cyc;
    wait_n = 0;
    do_reset();
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(1, 32'h0, 32'h4, 1, 32'h4));
    push(s0(), mk_e(1, 32'h1, 32'h8, 1, 32'h8));
    for (int k = 0; k < 3; k++)
      push(mk_s(1, 2'b00, 26'h0, 32'h0, 0, 32'h0), mk_e(1, 32'h1, 32'h8, 0, 32'h0));
    push(s0(), mk_e(1, 32'h2, 32'hC, 1, 32'hC));
    push(s0(), mk_e(1, 32'h3, 32'h10, 1, 32'h10));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL stall c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_jr_stall();
    stim_t s; exp_t e; int cyc;
    push(mk_s(1, 2'b10, 26'h0, 32'h1234, 0, 32'h0), mk_e(1, 32'h3, 32'h10, 0, 32'h0));
    push(mk_s(1, 2'b10, 26'h0, 32'h1234, 0, 32'h0), mk_e(1, 32'h3, 32'h10, 0, 32'h0));
    push(mk_s(0, 2'b10, 26'h0, 32'h1234, 0, 32'h0), mk_e(0, 32'h0, 32'h0, 1, 32'h1234));
    push(s0(), mk_e(1, 32'h48D, 32'h1238, 1, 32'h1238));
    push(mk_s(1, 2'b10, 26'h0, 32'h2000, 1, 32'h40), mk_e(0, 32'h0, 32'h0, 1, 32'h40));
    push(s0(), mk_e(1, 32'h10, 32'h44, 1, 32'h44));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL jr_stall c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s; exp_t e; int cyc;
    push(mk_s(0, 2'b10, 26'h0, 32'hFFFF_FFFC, 0, 32'h0), mk_e(0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC));
    push(s0(), mk_e(1, 32'h3FFF_FFFF, 32'h0, 1, 32'h0));
    push(s0(), mk_e(1, 32'h0, 32'h4, 1, 32'h4));
    push(mk_s(0, 2'b10, 26'h0, 32'h1002, 0, 32'h0), mk_e(0, 32'h0, 32'h0, 1, 32'h1002));
    push(s0(), mk_e(1, 32'h400, 32'h1006, 1, 32'h1006));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL wrap c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  task automatic test_reset_drain();
    stim_t s; exp_t e; int cyc;
    wait_n = 5;
    do_reset();
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(mk_s(0, 2'b00, 26'h0, 32'h0, 1, 32'h80), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    push(s0(), mk_e(0, 32'h0, 32'h0, 1, 32'h0));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL drain c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
    // Reset lands mid-cycle while the stale request is outstanding
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc4} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got req=%0d v=%0d instr=%h pc4=%h, want 0 0 00000000 00000000",
               imem_req, if_id_valid, if_id_instr, if_id_pc4);
    end
    ack_force = 1'b1;
    wait_n = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    ack_force = 1'b0;
    n_vec++;
    if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL restart: got v=%0d req=%0d addr=%h, want v=0 req=1 addr=00000000",
               if_id_valid, imem_req, imem_addr);
    end
    push(s0(), mk_e(1, 32'h0, 32'h4, 1, 32'h4));
    push(s0(), mk_e(1, 32'h1, 32'h8, 1, 32'h8));
    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front(); cyc++;
      apply(s);
      @(posedge clk); #1;
      n_vec++;
      if ({if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0), imem_req, (imem_req ? imem_addr : 32'h0)} !==
          {e.valid, e.instr, (e.valid ? e.pc4 : 32'h0), e.req, (e.req ? e.addr : 32'h0)}) begin
        n_err++;
        $display("FAIL post_reset c%0d: got v=%0d instr=%h pc4=%h req=%0d addr=%h, want v=%0d instr=%h pc4=%h req=%0d addr=%h",
                 cyc, if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr, e.valid, e.instr, e.pc4, e.req, e.addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_jump();
    test_branch_wait();
    test_stall();
    test_jr_stall();
    test_wrap();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
